// File: rtl/pong_pkg.sv
// Shared types for the quadrature paddle emulator: move FSM states and the
// sizing helper for the edge-rate timer.
package pong_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    TRAIL = 2'd2
  } state_t;

  // Bits needed to hold values 0..edge_cycles.
  function automatic int timer_width(input int edge_cycles);
    return (edge_cycles < 1) ? 1 : $clog2(edge_cycles + 1);
  endfunction

endpackage

// File: rtl/edge_timer.sv
// Loadable down-counter with a zero flag; usable as a fixed-rate strobe
// generator by reloading it whenever it reaches zero.
module edge_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         enable,
  output logic [W-1:0] count,
  output logic         zero
);

  logic [W-1:0] count_r;

  // Counter register: load has priority, otherwise count down and stick at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= {W{1'b0}};
    end else if (load) begin
      count_r <= load_value;
    end else if (enable && (count_r != {W{1'b0}})) begin
      count_r <= count_r - W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign zero  = (count_r == {W{1'b0}});

endmodule

// File: rtl/quad_encoder_emulator.sv
// Drives quadrature A/B so a same-clock decoder counts from its current value to
// an accepted target, one count (lead edge + trail edge) at a time.
module quad_encoder_emulator
  import pong_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int EDGE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] target,
  input  logic             target_valid,
  output logic             target_ready,
  output logic             a,
  output logic             b,
  output logic [WIDTH-1:0] position,
  output logic             busy,
  output logic             done
);

  localparam int            TW     = timer_width(EDGE_CYCLES);
  localparam logic [TW-1:0] RELOAD = TW'(EDGE_CYCLES - 1);

  state_t           state_r;
  state_t           state_s;
  logic             a_r;
  logic             b_r;
  logic [WIDTH-1:0] position_r;
  logic [WIDTH-1:0] tgt_q_r;
  logic             pending_r;
  logic             done_r;
  logic             step_up_r;

  logic             accept_s;
  logic             up_s;
  logic             lead_s;
  logic             trail_s;
  logic             finish_s;
  logic             timer_load_s;
  logic             timer_en_s;
  logic [TW-1:0]    timer_count_s;
  logic             timer_zero_s;

  assign target_ready = (state_r == IDLE) && !pending_r;
  assign busy         = (state_r != IDLE) || pending_r;
  assign accept_s     = target_valid && target_ready;
  assign up_s         = (tgt_q_r > position_r);
  assign timer_en_s   = (state_r != IDLE);

  edge_timer #(
    .W (TW)
  ) u_edge_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load_s),
    .load_value (RELOAD),
    .enable     (timer_en_s),
    .count      (timer_count_s),
    .zero       (timer_zero_s)
  );

  // Next-state and edge-request decode; a latched target is resolved the cycle after the handshake.
  always_comb begin
    state_s      = state_r;
    lead_s       = 1'b0;
    trail_s      = 1'b0;
    finish_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (pending_r) begin
          if (tgt_q_r == position_r) begin
            finish_s = 1'b1;
            state_s  = IDLE;
          end else begin
            lead_s  = 1'b1;
            state_s = LEAD;
          end
        end else begin
          state_s = IDLE;
        end
      end
      LEAD: begin
        if (timer_zero_s) begin
          trail_s = 1'b1;
          state_s = TRAIL;
        end else begin
          state_s = LEAD;
        end
      end
      TRAIL: begin
        if (timer_zero_s) begin
          if (position_r != tgt_q_r) begin
            lead_s  = 1'b1;
            state_s = LEAD;
          end else begin
            finish_s = 1'b1;
            state_s  = IDLE;
          end
        end else begin
          state_s = TRAIL;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    timer_load_s = lead_s | trail_s;
  end

  // State, line and shadow-count registers; position moves with the counting (lead) edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      a_r        <= 1'b0;
      b_r        <= 1'b0;
      position_r <= {WIDTH{1'b0}};
      tgt_q_r    <= {WIDTH{1'b0}};
      pending_r  <= 1'b0;
      done_r     <= 1'b0;
      step_up_r  <= 1'b0;
    end else begin
      state_r   <= state_s;
      done_r    <= finish_s;
      pending_r <= accept_s;
      if (accept_s) begin
        tgt_q_r <= target;
      end
      if (lead_s) begin
        step_up_r <= up_s;
        if (up_s) begin
          position_r <= position_r + WIDTH'(1);
          a_r        <= ~a_r;
        end else begin
          position_r <= position_r - WIDTH'(1);
          b_r        <= ~b_r;
        end
      end else if (trail_s) begin
        // Trail edge uses the direction of the step already started.
        if (step_up_r) begin
          b_r <= ~b_r;
        end else begin
          a_r <= ~a_r;
        end
      end
    end
  end

  assign a        = a_r;
  assign b        = b_r;
  assign position = position_r;
  assign done     = done_r;

endmodule

// File: tb/tb_quad_encoder_emulator.sv
// Self-checking bench: a behavioural quadrature decoder model follows the A/B
// lines and every move is checked for edge rules, spacing, count and done latency.
module tb_quad_encoder_emulator;

  localparam int WIDTH = 8;
  localparam int E     = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] target;
  logic             target_valid;
  logic             target_ready;
  logic             a;
  logic             b;
  logic [WIDTH-1:0] position;
  logic             busy;
  logic             done;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int model_count = 0;

  quad_encoder_emulator #(
    .WIDTH       (WIDTH),
    .EDGE_CYCLES (E)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .target       (target),
    .target_valid (target_valid),
    .target_ready (target_ready),
    .a            (a),
    .b            (b),
    .position     (position),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One full move: handshake, then watch every cycle until done (bounded).
  task automatic do_move(input logic [WIDTH-1:0] t, input bit inject, input logic [WIDTH-1:0] junk);
    int   n;
    int   last_edge;
    int   edges;
    int   wait_cnt;
    int   nchg;
    int   extra_done;
    logic pa;
    logic pb;
    bit   seen_done;
    n = (int'(t) > model_count) ? int'(t) - model_count : model_count - int'(t);
    wait_cnt = 0;
    while (!target_ready && wait_cnt < 100) begin
      @(negedge clk);
      wait_cnt++;
    end
    chk("ready_before_hs", {31'd0, target_ready}, 32'd1);
    target       = t;
    target_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    target_valid = 1'b0;
    chk("ready_low_after_hs", {31'd0, target_ready}, 32'd0);
    pa        = a;
    pb        = b;
    last_edge = 0;
    edges     = 0;
    seen_done = 1'b0;
    for (int k = 1; !seen_done && k <= 2 * n * E + 20; k++) begin
      @(negedge clk);
      target_valid = inject && (k == 3);
      target       = (inject && (k == 3)) ? junk : t;
      if ((a !== pa) || (b !== pb)) begin
        nchg = ((a !== pa) ? 1 : 0) + ((b !== pb) ? 1 : 0);
        chk("single_line_toggle", nchg, 32'd1);
        chk("edge_spacing", k - last_edge, (edges == 0) ? 32'd1 : E);
        if (a !== b) begin
          model_count = (a !== pa) ? model_count + 1 : model_count - 1;
        end
        chk("decoder_vs_position", {24'd0, position}, model_count);
        last_edge = k;
        edges++;
        pa = a;
        pb = b;
      end
      if (done === 1'b1) begin
        seen_done = 1'b1;
        chk("done_latency", k, 2 * n * E + 1);
      end
    end
    target_valid = 1'b0;
    if (!seen_done) chk("done_timeout", 32'd0, 32'd1);
    chk("edge_count", edges, 2 * n);
    chk("final_position", {24'd0, position}, {24'd0, t});
    chk("decoder_final", model_count, {24'd0, t});
    chk("rest_phase", {30'd0, a, b}, t[0] ? 32'd3 : 32'd0);
    @(negedge clk);
    chk("done_single_cycle", {31'd0, done}, 32'd0);
    chk("ready_in_idle", {31'd0, target_ready}, 32'd1);
    chk("busy_in_idle", {31'd0, busy}, 32'd0);
    if (inject) begin
      extra_done = 0;
      for (int j = 0; j < 10; j++) begin
        @(negedge clk);
        if (done === 1'b1) extra_done++;
      end
      chk("ignored_no_extra_done", extra_done, 32'd0);
      chk("ignored_position_held", {24'd0, position}, {24'd0, t});
    end
  endtask

  initial begin
    logic [31:0] r;
    reset        = 1'b1;
    target_valid = 1'b0;
    target       = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_a", {31'd0, a}, 32'd0);
    chk("reset_b", {31'd0, b}, 32'd0);
    chk("reset_position", {24'd0, position}, 32'd0);
    chk("reset_ready", {31'd0, target_ready}, 32'd1);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    reset       = 1'b0;
    model_count = 0;

    do_move(8'd3, 1'b0, 8'd0);
    do_move(8'd1, 1'b0, 8'd0);
    do_move(8'd5, 1'b0, 8'd0);
    do_move(8'd5, 1'b0, 8'd0);
    do_move(8'd4, 1'b1, 8'd9);
    do_move(8'd0, 1'b0, 8'd0);

    // Reset during LEAD of a 0->6 move.
    target       = 8'd6;
    target_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    target_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("busy_mid_move", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset       = 1'b0;
    model_count = 0;
    chk("midreset_a", {31'd0, a}, 32'd0);
    chk("midreset_b", {31'd0, b}, 32'd0);
    chk("midreset_position", {24'd0, position}, 32'd0);
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    chk("midreset_ready", {31'd0, target_ready}, 32'd1);
    chk("midreset_done", {31'd0, done}, 32'd0);
    do_move(8'd2, 1'b0, 8'd0);

    do_move(8'd255, 1'b0, 8'd0);
    do_move(8'd0, 1'b0, 8'd0);
    do_move(8'd128, 1'b0, 8'd0);
    for (int i = 0; i < 12; i++) begin
      r = $urandom_range(0, 255);
      do_move(r[7:0], ($urandom_range(0, 3) == 0), 8'd77);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/quad_encoder_emulator.md
Name: quad_encoder_emulator

Overview:
Drives quadrature A/B lines so that the team's quadrature decoder, clocked on the same `clk`, counts from its current value to a commanded target. The block is used as a synthetic paddle source: for CPU/AI paddle emulation, demo mode, and decoder loopback self-test. It holds a shadow `position` equal to the count the decoder will show. It moves toward an accepted target one count at a time, with rate-limited edges.

Parameters:
- WIDTH, 8, width of target/position; must match the decoder's WIDTH.
- EDGE_CYCLES, 4, clocks between consecutive A/B edges; legal range ≥1.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- target  input  WIDTH  requested decoder count
- target_valid  input  1  target offered
- target_ready  output  1  high only in IDLE; transfer when valid && ready
- a  output  1  quadrature channel A, registered
- b  output  1  quadrature channel B, registered
- position  output  WIDTH  count the decoder reports once the last counting edge has been sampled
- busy  output  1  high when state != IDLE
- done  output  1  one-cycle pulse on return to IDLE after an accepted target

Behaviour:
Decoder contract, with state written as (a,b):
- +1 on A rising while B=0, or A falling while B=1.
- −1 on B rising while A=0, or B falling while A=1.
- Every other transition: no count.

Unit step:
- One count = two edges, a counting "lead" edge then a non-counting "trail" edge.
- Rest phase is therefore always 00 or 11.
- Up step: toggle a, then toggle b.
- Down step: toggle b, then toggle a.
- Valid from either rest phase: 00→10→11, 11→01→00 (up); 00→01→11, 11→10→00 (down).

Reset:
- state=IDLE, a=0, b=0, position=0, timer=0, done=0.
- target_ready=1 and busy=0 (both derived from state).
- Reset mid-move abandons the move immediately. The decoder shares the reset, so both return to 0 together.

FSM states: IDLE, LEAD, TRAIL. Signed direction is dir = (tgt_q > position).
- IDLE:
  - On a handshake, latch tgt_q.
  - If tgt_q == position: pulse done next cycle, no edges.
  - Else: next cycle toggle the lead line, update position by ±1 in the same register update, load timer=EDGE_CYCLES−1, go LEAD.
- LEAD, timer==0: toggle the trail line, reload timer, go TRAIL.
- TRAIL, timer==0:
  - If position != tgt_q: emit the next lead edge (same as IDLE exit), go LEAD.
  - Else: go IDLE, done=1 for one cycle.
- Timer counts down by 1 each cycle in LEAD/TRAIL.
- Edge spacing is exactly EDGE_CYCLES clocks, including across step boundaries.
- First edge follows the handshake by 1 cycle.

Handshake and targets:
- target_valid is ignored while busy; no queuing or retarget mid-move.
- The upstream holds valid until ready.
- tgt_q is always in range, so position never wraps and never hits the decoder saturation guard.
- Move of N counts: 2N edges, done asserted 2N·EDGE_CYCLES+1 cycles after the handshake cycle.

Outputs:
- a, b, position, done are all flops.
- a and b never change in the same cycle.

Decomposition:
- Shared package `pong_pkg`: state enum {IDLE, LEAD, TRAIL}, localparam function for timer width $clog2(EDGE_CYCLES+1).
- One natural sub-module, `edge_timer`: loadable down-counter with a zero flag, reused for any fixed-rate strobe.
- Everything else lives inline.

Test Plan:
1. Reset, then target=3 with EDGE_CYCLES=4 → (a,b) sequence 00,10,11,01,00,10,11, edges 4 clocks apart; position 1,2,3; done 25 cycles after the handshake.
2. From position 3 (rest 11), target=1 → 11,10,00,01,11; position 2,1; a/b never toggle together.
3. target == position (5→5) → no edges, done the next cycle, ready stays high except that cycle.
4. Loopback with the decoder (WIDTH=8, EDGE_CYCLES=1): targets 0→255→0→128 → decoder value equals position at every done; final 128.
5. target_valid pulsed with target=9 while busy toward 4 → ignored; final position 4, single done.
6. Assert reset in LEAD during a move 0→6 → next cycle a=b=0, position=0, busy=0; a new target=2 then completes normally.
